// File: rtl/ft64_div_sched.sv
// Shares one iterative FT64 divider between NREQ ALU issue ports: round-robin grant,
// operand latch, result hold over valid/ready, and tag-based flush/abort.
module ft64_div_sched #(
    parameter int unsigned WID  = 64,
    parameter int unsigned NREQ = 2,
    parameter int unsigned TAGW = 5,
    localparam int unsigned SRCW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_v,
    output logic [NREQ-1:0]      req_rdy,
    input  logic [NREQ-1:0]      req_sgn,
    input  logic [NREQ-1:0]      req_sgnus,
    input  logic [NREQ*WID-1:0]  req_a,
    input  logic [NREQ*WID-1:0]  req_b,
    input  logic [NREQ*TAGW-1:0] req_tag,
    output logic                 div_ld,
    output logic                 div_abort,
    output logic                 div_sgn,
    output logic                 div_sgnus,
    output logic [WID-1:0]       div_a,
    output logic [WID-1:0]       div_b,
    input  logic [WID-1:0]       div_qo,
    input  logic [WID-1:0]       div_ro,
    input  logic                 div_dvByZr,
    input  logic                 div_done,
    input  logic                 div_idle,
    output logic                 res_v,
    input  logic                 res_rdy,
    output logic [TAGW-1:0]      res_tag,
    output logic [SRCW-1:0]      res_src,
    output logic [WID-1:0]       res_q,
    output logic [WID-1:0]       res_r,
    output logic                 res_dbz,
    input  logic                 flush_v,
    input  logic [TAGW-1:0]      flush_tag,
    output logic                 busy
);

    typedef enum logic [1:0] {IDLE, LOAD, BUSY, HOLD} state_t;

    state_t          state_q, state_d;
    logic [SRCW-1:0] rr_q, rr_d;
    logic            killed_q, killed_d;
    logic [WID-1:0]  a_q, a_d, b_q, b_d;
    logic            sgn_q, sgn_d, sgnus_q, sgnus_d;
    logic [TAGW-1:0] tag_q, tag_d;
    logic [SRCW-1:0] src_q, src_d;
    logic            resv_q, resv_d;
    logic [WID-1:0]  resq_q, resq_d, resr_q, resr_d;
    logic            resdbz_q, resdbz_d;
    logic [TAGW-1:0] restag_q, restag_d;
    logic [SRCW-1:0] ressrc_q, ressrc_d;

    logic            gnt_found;
    int unsigned     gnt_i;
    logic            flush_hit;
    logic            kill_now;

    // First requester at or after rr_q, wrapping around the port list.
    always_comb begin
        gnt_found = 1'b0;
        gnt_i     = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            int unsigned idx;
            idx = 32'(rr_q) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!gnt_found && req_v[idx]) begin
                gnt_found = 1'b1;
                gnt_i     = idx;
            end
        end
    end

    assign flush_hit = flush_v && (flush_tag == tag_q);
    assign kill_now  = killed_q || flush_hit;

    always_comb begin
        state_d   = state_q;
        rr_d      = rr_q;
        killed_d  = killed_q;
        a_d       = a_q;
        b_d       = b_q;
        sgn_d     = sgn_q;
        sgnus_d   = sgnus_q;
        tag_d     = tag_q;
        src_d     = src_q;
        resv_d    = resv_q;
        resq_d    = resq_q;
        resr_d    = resr_q;
        resdbz_d  = resdbz_q;
        restag_d  = restag_q;
        ressrc_d  = ressrc_q;
        req_rdy   = '0;
        div_ld    = 1'b0;
        div_abort = 1'b0;

        case (state_q)
            IDLE: begin
                if (!rst && gnt_found && div_idle) begin
                    req_rdy[gnt_i] = 1'b1;
                    a_d      = req_a[gnt_i*WID +: WID];
                    b_d      = req_b[gnt_i*WID +: WID];
                    sgn_d    = req_sgn[gnt_i];
                    sgnus_d  = req_sgnus[gnt_i];
                    tag_d    = req_tag[gnt_i*TAGW +: TAGW];
                    src_d    = SRCW'(gnt_i);
                    killed_d = flush_v && (flush_tag == req_tag[gnt_i*TAGW +: TAGW]);
                    rr_d     = (gnt_i == NREQ - 1) ? '0 : SRCW'(gnt_i + 1);
                    state_d  = LOAD;
                end
            end
            LOAD: begin
                div_ld = 1'b1;
                if (flush_hit) killed_d = 1'b1;
                state_d = BUSY;
            end
            BUSY: begin
                div_abort = kill_now;
                // div_done alone is also high while the divider idles
                if (div_done && !div_idle) begin
                    if (kill_now) begin
                        killed_d = 1'b0;
                        state_d  = IDLE;
                    end else begin
                        resq_d   = div_qo;
                        resr_d   = div_ro;
                        resdbz_d = div_dvByZr;
                        restag_d = tag_q;
                        ressrc_d = src_q;
                        resv_d   = 1'b1;
                        state_d  = HOLD;
                    end
                end else if (flush_hit) begin
                    killed_d = 1'b1;
                end
            end
            HOLD: begin
                if (res_rdy || flush_hit) begin
                    resv_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            rr_q     <= '0;
            killed_q <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            sgn_q    <= 1'b0;
            sgnus_q  <= 1'b0;
            tag_q    <= '0;
            src_q    <= '0;
            resv_q   <= 1'b0;
            resq_q   <= '0;
            resr_q   <= '0;
            resdbz_q <= 1'b0;
            restag_q <= '0;
            ressrc_q <= '0;
        end else begin
            state_q  <= state_d;
            rr_q     <= rr_d;
            killed_q <= killed_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sgn_q    <= sgn_d;
            sgnus_q  <= sgnus_d;
            tag_q    <= tag_d;
            src_q    <= src_d;
            resv_q   <= resv_d;
            resq_q   <= resq_d;
            resr_q   <= resr_d;
            resdbz_q <= resdbz_d;
            restag_q <= restag_d;
            ressrc_q <= ressrc_d;
        end
    end

    assign div_a     = a_q;
    assign div_b     = b_q;
    assign div_sgn   = sgn_q;
    assign div_sgnus = sgnus_q;
    assign res_v     = resv_q;
    assign res_q     = resq_q;
    assign res_r     = resr_q;
    assign res_dbz   = resdbz_q;
    assign res_tag   = restag_q;
    assign res_src   = ressrc_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_ft64_div_sched.sv
// Directed bench for ft64_div_sched with a behavioural stand-in for the FT64 divider
// (IDLE -> 66 compute cycles -> DONE for one cycle; abort jumps straight to DONE).
module tb_ft64_div_sched;

    localparam int WID = 64;
    localparam int NREQ = 2;
    localparam int TAGW = 5;
    localparam logic [63:0] MAXP = 64'h7FFF_FFFF_FFFF_FFFF;

    logic                 clk = 0;
    logic                 rst = 1;
    logic [NREQ-1:0]      req_v = '0, req_rdy, req_sgn = '0, req_sgnus = '0;
    logic [NREQ*WID-1:0]  req_a = '0, req_b = '0;
    logic [NREQ*TAGW-1:0] req_tag = '0;
    logic                 div_ld, div_abort, div_sgn, div_sgnus;
    logic [WID-1:0]       div_a, div_b, div_qo, div_ro;
    logic                 div_dvByZr, div_done, div_idle;
    logic                 res_v, res_rdy = 0, res_dbz, busy;
    logic [TAGW-1:0]      res_tag;
    logic [0:0]           res_src;
    logic [WID-1:0]       res_q, res_r;
    logic                 flush_v = 0;
    logic [TAGW-1:0]      flush_tag = '0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ft64_div_sched #(.WID(WID), .NREQ(NREQ), .TAGW(TAGW)) dut (
        .clk(clk), .rst(rst),
        .req_v(req_v), .req_rdy(req_rdy), .req_sgn(req_sgn), .req_sgnus(req_sgnus),
        .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
        .div_ld(div_ld), .div_abort(div_abort), .div_sgn(div_sgn), .div_sgnus(div_sgnus),
        .div_a(div_a), .div_b(div_b), .div_qo(div_qo), .div_ro(div_ro),
        .div_dvByZr(div_dvByZr), .div_done(div_done), .div_idle(div_idle),
        .res_v(res_v), .res_rdy(res_rdy), .res_tag(res_tag), .res_src(res_src),
        .res_q(res_q), .res_r(res_r), .res_dbz(res_dbz),
        .flush_v(flush_v), .flush_tag(flush_tag), .busy(busy)
    );

    // ---------------- divider model ----------------
    typedef enum logic [1:0] {D_IDLE, D_RUN, D_DONE} dst_t;
    typedef struct packed { logic [63:0] q; logic [63:0] r; logic dbz; } dres_t;
    dst_t        dst;
    int          dcnt;
    logic [63:0] mq, mr;
    logic        mdbz;

    function automatic dres_t divide(logic [63:0] a, logic [63:0] b, logic s, logic su);
        dres_t o;
        logic [63:0] mag, q0, r0;
        o.dbz = 1'b0;
        if (b == 0) begin
            o.q = MAXP; o.r = MAXP; o.dbz = 1'b1;
        end else if (s) begin
            o.q = $signed(a) / $signed(b);
            o.r = $signed(a) % $signed(b);
        end else if (su) begin
            mag = a[63] ? -a : a;
            q0  = mag / b;
            r0  = mag % b;
            o.q = a[63] ? -q0 : q0;
            o.r = a[63] ? -r0 : r0;
        end else begin
            o.q = a / b;
            o.r = a % b;
        end
        return o;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            dst <= D_IDLE; dcnt <= 0; mq <= '0; mr <= '0; mdbz <= 1'b0;
        end else begin
            case (dst)
                D_IDLE: if (div_ld) begin
                    {mq, mr, mdbz} <= divide(div_a, div_b, div_sgn, div_sgnus);
                    dcnt <= 65;
                    dst  <= D_RUN;
                end
                D_RUN: begin
                    if (div_abort || dcnt == 0) dst <= D_DONE;
                    else dcnt <= dcnt - 1;
                end
                default: dst <= D_IDLE;
            endcase
        end
    end

    assign div_qo     = mq;
    assign div_ro     = mr;
    assign div_dvByZr = mdbz;
    assign div_idle   = (dst == D_IDLE);
    assign div_done   = (dst == D_DONE) || (dst == D_IDLE);

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Presents a single request, waits for its grant, then confirms the load cycle.
    task automatic start_op(input int p, input logic [63:0] a, input logic [63:0] b,
                            input logic s, input logic su, input logic [4:0] tag);
        int n;
        @(negedge clk);
        req_v = '0;
        req_v[p] = 1'b1;
        req_a[p*WID +: WID] = a;
        req_b[p*WID +: WID] = b;
        req_sgn[p] = s;
        req_sgnus[p] = su;
        req_tag[p*TAGW +: TAGW] = tag;
        #1;
        n = 0;
        while (req_rdy == '0 && n < 10) begin @(negedge clk); #1; n++; end
        chk("grant", 64'(req_rdy), 64'(1 << p));
        @(negedge clk);
        req_v = '0;
        #1;
        chk("div_ld", 64'(div_ld), 64'd1);
        chk("div_a", div_a, a);
        chk("div_b", div_b, b);
    endtask

    // Called one cycle after grant; returns cycles since grant when res_v is seen.
    task automatic wait_res(output int lat);
        lat = 1;
        while (!res_v && lat < 200) begin @(negedge clk); #1; lat++; end
        chk("res_v_seen", 64'(res_v), 64'd1);
    endtask

    task automatic accept();
        res_rdy = 1'b1;
        @(negedge clk);
        res_rdy = 1'b0;
        #1;
        chk("res_v_after_rdy", 64'(res_v), 64'd0);
    endtask

    typedef struct {
        int p; logic [63:0] a, b; logic s, su; logic [4:0] tag;
        logic [63:0] q, r; logic dbz;
    } vec_t;
    vec_t vt[6];

    initial begin
        int lat, n;
        logic ok;
        logic [63:0] q0, r0;
        vt[0] = '{0, 64'd10005, 64'd27, 1'b0, 1'b0, 5'd3, 64'd370, 64'd15, 1'b0};
        vt[1] = '{1, -64'd10005, 64'd27, 1'b1, 1'b0, 5'd9, -64'd370, -64'd15, 1'b0};
        vt[2] = '{0, -64'd10005, 64'd27, 1'b0, 1'b1, 5'd12, -64'd370, -64'd15, 1'b0};
        vt[3] = '{1, 64'd5, 64'd0, 1'b0, 1'b0, 5'd20, MAXP, MAXP, 1'b1};
        vt[4] = '{0, 64'd1000, 64'd1000, 1'b0, 1'b0, 5'd31, 64'd1, 64'd0, 1'b0};
        vt[5] = '{1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 1'b0, 1'b0, 5'd0, MAXP, 64'd1, 1'b0};

        repeat (3) @(negedge clk);
        rst = 0;
        #1;
        chk("rst_busy", 64'(busy), 0);
        chk("rst_res_v", 64'(res_v), 0);
        chk("rst_div_ld", 64'(div_ld), 0);
        chk("rst_res_q", res_q, 0);
        chk("rst_div_a", div_a, 0);

        // table-driven single transactions
        foreach (vt[i]) begin
            start_op(vt[i].p, vt[i].a, vt[i].b, vt[i].s, vt[i].su, vt[i].tag);
            wait_res(lat);
            chk("latency", 64'(lat), 64'd69);
            chk("res_q", res_q, vt[i].q);
            chk("res_r", res_r, vt[i].r);
            chk("res_dbz", 64'(res_dbz), 64'(vt[i].dbz));
            chk("res_tag", 64'(res_tag), 64'(vt[i].tag));
            chk("res_src", 64'(res_src), 64'(vt[i].p));
            accept();
            chk("idle_after", 64'(busy), 0);
        end

        // both ports request continuously: rotation 0,1,0,1
        @(negedge clk);
        req_a = {64'd100, 64'd100};
        req_b = {64'd9, 64'd7};
        req_sgn = '0; req_sgnus = '0;
        req_tag = {5'd2, 5'd1};
        req_v = 2'b11;
        #1;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            while (req_rdy == '0 && n < 10) begin @(negedge clk); #1; n++; end
            chk("rr_grant", 64'(req_rdy), (k % 2 == 0) ? 64'd1 : 64'd2);
            if (k == 3) begin @(negedge clk); req_v = '0; #1; end
            ok = 1'b1;
            lat = 0;
            while (!res_v && lat < 200) begin
                @(negedge clk); #1; lat++;
                if (req_rdy != '0) ok = 1'b0;
            end
            q0 = res_q; r0 = res_r;
            repeat (10) begin
                @(negedge clk); #1;
                if (!res_v || res_q !== q0 || res_r !== r0 || req_rdy != '0) ok = 1'b0;
            end
            chk("rr_no_grant_and_stable", 64'(ok), 64'd1);
            chk("rr_q", res_q, (k % 2 == 0) ? 64'd14 : 64'd11);
            chk("rr_r", res_r, (k % 2 == 0) ? 64'd2 : 64'd1);
            chk("rr_src", 64'(res_src), 64'(k % 2));
            res_rdy = 1'b1;
            @(negedge clk);
            res_rdy = 1'b0;
            #1;
        end
        chk("rr_done_idle", 64'(busy), 0);

        // matching flush mid-BUSY aborts and drops the result
        start_op(0, 64'd10005, 64'd27, 1'b0, 1'b0, 5'd7);
        repeat (10) @(negedge clk);
        flush_v = 1'b1; flush_tag = 5'd7;
        #1;
        chk("abort_on_flush", 64'(div_abort), 64'd1);
        @(negedge clk);
        flush_v = 1'b0;
        #1;
        n = 1;
        while (busy && n < 4) begin @(negedge clk); #1; n++; end
        chk("flush_busy_low", 64'(busy), 0);
        ok = 1'b1;
        repeat (80) begin @(negedge clk); #1; if (res_v) ok = 1'b0; end
        chk("flush_no_result", 64'(ok), 64'd1);
        start_op(1, 64'd77, 64'd10, 1'b0, 1'b0, 5'd8);
        wait_res(lat);
        chk("post_flush_latency", 64'(lat), 64'd69);
        chk("post_flush_q", res_q, 64'd7);
        chk("post_flush_r", res_r, 64'd7);
        accept();

        // non-matching flush in BUSY has no effect
        start_op(0, 64'd50, 64'd8, 1'b0, 1'b0, 5'd4);
        repeat (5) @(negedge clk);
        flush_v = 1'b1; flush_tag = 5'd5;
        #1;
        chk("no_abort_mismatch", 64'(div_abort), 0);
        @(negedge clk);
        flush_v = 1'b0;
        #1;
        wait_res(lat);
        chk("mismatch_q", res_q, 64'd6);
        chk("mismatch_r", res_r, 64'd2);
        accept();

        // matching flush while holding the result
        start_op(1, 64'd9, 64'd3, 1'b0, 1'b0, 5'd11);
        wait_res(lat);
        flush_v = 1'b1; flush_tag = 5'd11;
        @(negedge clk);
        flush_v = 1'b0;
        #1;
        chk("hold_flush_res_v", 64'(res_v), 0);
        chk("hold_flush_busy", 64'(busy), 0);

        // non-matching flush while holding
        start_op(0, 64'd9, 64'd4, 1'b0, 1'b0, 5'd13);
        wait_res(lat);
        flush_v = 1'b1; flush_tag = 5'd14;
        @(negedge clk);
        flush_v = 1'b0;
        #1;
        chk("hold_mismatch_res_v", 64'(res_v), 64'd1);
        chk("hold_mismatch_tag", 64'(res_tag), 64'd13);
        chk("hold_mismatch_q", res_q, 64'd2);
        accept();

        // reset during BUSY
        start_op(1, 64'd1234, 64'd5, 1'b0, 1'b0, 5'd17);
        repeat (20) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk("mid_rst_busy", 64'(busy), 0);
        chk("mid_rst_div_ld", 64'(div_ld), 0);
        chk("mid_rst_abort", 64'(div_abort), 0);
        chk("mid_rst_res_v", 64'(res_v), 0);
        chk("mid_rst_div_a", div_a, 0);
        chk("mid_rst_div_b", div_b, 0);
        chk("mid_rst_res_q", res_q, 0);
        chk("mid_rst_rdy", 64'(req_rdy), 0);
        rst = 1'b0;
        start_op(0, 64'd1234, 64'd5, 1'b0, 1'b0, 5'd18);
        wait_res(lat);
        chk("post_rst_latency", 64'(lat), 64'd69);
        chk("post_rst_q", res_q, 64'd246);
        chk("post_rst_r", res_r, 64'd4);
        chk("post_rst_tag", 64'(res_tag), 64'd18);
        accept();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
